dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

- Frequency-sweep sequencer for one DDS channel. It sits between the SPI configuration register and the `dds` cfg input.
- When idle, it passes the static channel config straight through.
- When started, it overwrites the phase-increment field with a stepped sequence from start to stop, holding each point for a programmable dwell.
- It emits a per-step strobe that the ADC trigger path can use for swept-response capture.

## Interface
Parameters:
- INC_W, 24, width of the phase-increment field; occupies cfg bits [INC_W-1:0]
- DWELL_W, 24, width of the dwell counter
- IDX_W, 16, width of the point index

Ports:
- clk  in  1  system clock (pll_clk domain)
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_in  in  32  static DDS config from SPI block
- start_inc  in  INC_W  first increment
- step_inc  in  INC_W  unsigned step magnitude
- stop_inc  in  INC_W  sweep limit (inclusive)
- dir_down  in  1  0 = ascending, 1 = descending
- dwell  in  DWELL_W  each point is held dwell+1 cycles
- repeat  in  1  1 = restart at start_inc after the last point
- start  in  1  level-sampled start request
- abort  in  1  synchronous abort
- cfg_out  out  32  config to `dds` cfg input
- busy  out  1  sweep in progress
- step_stb  out  1  one-cycle pulse whenever a new point is applied
- done  out  1  one-cycle pulse at end of each pass
- point_idx  out  IDX_W  index of current point within the pass

## Operation
- States: IDLE, RUN.
- Reset:
  - state=IDLE.
  - cfg_out=0, busy=0, step_stb=0, done=0, point_idx=0.
  - Internal increment and counters cleared.
- IDLE:
  - Each edge, cfg_out <= cfg_in (registered pass-through).
  - If start=1 and abort=0 at an edge:
    - Latch start_inc, step_inc, stop_inc, dir_down, dwell and repeat into shadow registers.
    - cur <= start_inc; cnt <= dwell; point_idx <= 0.
    - step_stb <= 1, busy <= 1, state <= RUN.
- RUN:
  - cfg_out = {cfg_in[31:INC_W] registered, cur}. Upper bits keep tracking cfg_in live.
  - Input changes to start_inc, step_inc, stop_inc, dir_down, dwell and repeat are ignored until the next start.
  - While cnt != 0: cnt decrements.
  - When cnt == 0, compute next:
    - Ascending: next = cur + step, computed INC_W+1 wide.
    - Descending: next = cur − step, computed INC_W+1 wide.
  - Next point exists iff no carry/borrow AND next <= stop (ascending) or next >= stop (descending) AND step != 0.
  - If the next point exists: cur <= next, cnt <= dwell, point_idx += 1 (saturating at all-ones), step_stb <= 1.
  - Else, end of pass: done <= 1.
    - If repeat=1: cur <= shadow start, cnt <= dwell, point_idx <= 0, step_stb <= 1; stay in RUN.
    - If repeat=0: state <= IDLE, busy <= 0, cfg_out <= cfg_in.
- Boundary conditions:
  - start_inc beyond stop in the sweep direction: exactly one point is emitted, then the pass ends.
  - step_inc=0: single point per pass. With repeat=1, the same point is re-strobed every dwell+1 cycles until abort.
  - Arithmetic never wraps: overflow or underflow ends the pass, and the emitted value is never outside [0, 2^INC_W−1].
  - abort=1 at any edge in RUN: state <= IDLE, busy <= 0, cfg_out <= cfg_in, no done pulse, no step_stb.
  - start in RUN: ignored.
  - start and abort in the same IDLE cycle: abort wins and the block stays idle.
  - Async reset mid-sweep: all outputs clear immediately. No done pulse after reset release.

## Timing
- Start latency: start sampled at edge k. After edge k: busy=1, cfg_out[INC_W-1:0]=start_inc, step_stb=1.
- Each point is visible on cfg_out for exactly dwell+1 cycles. step_stb is high during that point's first cycle.
- Non-repeat pass of N points: busy high for N·(dwell+1) cycles.
- done is high during the final cycle of busy. In that cycle cfg_out still holds the last point.
- Repeat wrap: done and step_stb are high in the same cycle, which is the first cycle of the new pass.
- All outputs registered. No combinational input-to-output paths.

## Test plan
- Ascending: start=100, step=50, stop=260, dwell=2, repeat=0 → increments 100, 150, 200, 250, each for 3 cycles. 4 step_stb pulses; busy for 12 cycles; done in cycle 12; point_idx 0..3; then cfg_out=cfg_in.
- Descending: start=10, step=4, stop=0, dir_down=1, dwell=0 → increments 10, 6, 2, one cycle each. Borrow on the next step ends the pass; done at cycle 3.
- Overflow: start=0xFFFFF0, step=0x20, stop=0xFFFFFF → single point 0xFFFFF0, done after dwell+1 cycles, no wrap to 0x000010.
- Repeat + abort: start=0, step=1, stop=2, dwell=1, repeat=1 → sequence 0,0,1,1,2,2,0,… with done at every wrap. Abort mid-point → busy=0 next cycle, no done, cfg_out=cfg_in.
- Start while busy ignored; start+abort together in IDLE leaves busy=0. cfg_in[31:24] changed mid-sweep → appears on cfg_out the next cycle.
- Async reset asserted mid-dwell → all outputs 0 immediately. After release, idle pass-through resumes and no spurious step_stb or done appears.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer for one DDS channel.
// Idle passes the static config through; a sweep replaces the increment field with stepped points.
module dds_sweep_ctrl #(
    parameter int INC_W   = 24,
    parameter int DWELL_W = 24,
    parameter int IDX_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        cfg_in,
    input  logic [INC_W-1:0]   start_inc,
    input  logic [INC_W-1:0]   step_inc,
    input  logic [INC_W-1:0]   stop_inc,
    input  logic               dir_down,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               repeat_en,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        cfg_out,
    output logic               busy,
    output logic               step_stb,
    output logic               done,
    output logic [IDX_W-1:0]   point_idx
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [INC_W-1:0]   cur, cur_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic               stb_d, done_d, busy_d, load;
    logic [31:0]        cfg_d;
    logic [INC_W:0]     nxt;
    logic               cur_ok;

    logic [INC_W-1:0]   start_s, step_s, stop_s;
    logic [DWELL_W-1:0] dwell_s;
    logic               down_s, rpt_s;

    // One extra bit catches carry (ascending) or borrow (descending).
    function automatic logic [INC_W:0] step_val(input logic [INC_W-1:0] v,
                                               input logic [INC_W-1:0] s,
                                               input logic dn);
        return dn ? ({1'b0, v} - {1'b0, s}) : ({1'b0, v} + {1'b0, s});
    endfunction

    function automatic logic has_next(input logic [INC_W-1:0] v,
                                      input logic [INC_W-1:0] s,
                                      input logic [INC_W-1:0] lim,
                                      input logic dn);
        logic [INC_W:0] n;
        n = step_val(v, s, dn);
        if (n[INC_W] || s == '0)
            return 1'b0;
        return dn ? (n[INC_W-1:0] >= lim) : (n[INC_W-1:0] <= lim);
    endfunction

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == '1) ? v : v + IDX_W'(1);
    endfunction

    // Without repeat, done is raised one edge early so it lands in the final busy cycle.
    always_comb begin
        state_d = state;
        cur_d   = cur;
        cnt_d   = cnt;
        idx_d   = point_idx;
        stb_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy;
        load    = 1'b0;
        nxt     = step_val(cur, step_s, down_s);
        cur_ok  = has_next(cur, step_s, stop_s, down_s);
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = RUN;
                    cur_d   = start_inc;
                    cnt_d   = dwell;
                    idx_d   = '0;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = !repeat_en && (dwell == '0) &&
                              !has_next(start_inc, step_inc, stop_inc, dir_down);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_d  = cnt - DWELL_W'(1);
                    done_d = !rpt_s && !cur_ok && (cnt == DWELL_W'(1));
                end else if (cur_ok) begin
                    cur_d  = nxt[INC_W-1:0];
                    cnt_d  = dwell_s;
                    idx_d  = sat_inc(point_idx);
                    stb_d  = 1'b1;
                    done_d = !rpt_s && (dwell_s == '0) &&
                             !has_next(nxt[INC_W-1:0], step_s, stop_s, down_s);
                end else if (rpt_s) begin
                    cur_d  = start_s;
                    cnt_d  = dwell_s;
                    idx_d  = '0;
                    stb_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_d = (state_d == RUN) ? {cfg_in[31:INC_W], cur_d} : cfg_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            point_idx <= '0;
            step_stb  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cfg_out   <= '0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            cnt       <= cnt_d;
            point_idx <= idx_d;
            step_stb  <= stb_d;
            done      <= done_d;
            busy      <= busy_d;
            cfg_out   <= cfg_d;
        end
    end

    // Sweep parameters are frozen at start; later input changes wait for the next start.
    always_ff @(posedge clk) begin
        if (load) begin
            start_s <= start_inc;
            step_s  <= step_inc;
            stop_s  <= stop_inc;
            down_s  <= dir_down;
            dwell_s <= dwell;
            rpt_s   <= repeat_en;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a point-list model fills a per-cycle scoreboard,
// and each cycle the DUT outputs are popped against it with immediate assertions.
module tb_dds_sweep_ctrl;

    localparam longint MAXV = 64'hFF_FFFF;

    typedef struct {
        logic        busy;
        logic        stb;
        logic        done;
        logic        idle;
        logic [23:0] inc;
        logic [15:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_in = '0;
    logic [23:0] start_inc = '0, step_inc = '0, stop_inc = '0;
    logic        dir_down = 1'b0;
    logic [23:0] dwell = '0;
    logic        repeat_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_out;
    logic        busy, step_stb, done;
    logic [15:0] point_idx;

    int    checks = 0;
    int    errors = 0;
    string phase = "reset";
    exp_t  sb[$];

    dds_sweep_ctrl #(.INC_W(24), .DWELL_W(24), .IDX_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_in(cfg_in),
        .start_inc(start_inc), .step_inc(step_inc), .stop_inc(stop_inc),
        .dir_down(dir_down), .dwell(dwell), .repeat_en(repeat_en),
        .start(start), .abort(abort), .cfg_out(cfg_out), .busy(busy),
        .step_stb(step_stb), .done(done), .point_idx(point_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.busy = 1'b0; e.stb = 1'b0; e.done = 1'b0; e.idle = 1'b1; e.inc = '0; e.idx = '0;
        sb.push_back(e);
    endtask

    // Expand a sweep into the expected per-cycle trace, capped at lim entries.
    task automatic push_sweep(input longint s, input longint st, input longint sp,
                              input bit dn, input int dw, input bit rp,
                              input int lim, output int cnt);
        longint pts[$];
        longint p, n;
        exp_t   e;
        pts.push_back(s);
        p = s;
        while (1) begin
            n = dn ? p - st : p + st;
            if (st == 0 || n < 0 || n > MAXV || (!dn && n > sp) || (dn && n < sp)) break;
            pts.push_back(n);
            p = n;
        end
        cnt = 0;
        for (int pass = 0; cnt < lim; pass++) begin
            for (int i = 0; i < pts.size() && cnt < lim; i++) begin
                for (int d = 0; d <= dw && cnt < lim; d++) begin
                    e.busy = 1'b1;
                    e.stb  = (d == 0);
                    e.idle = 1'b0;
                    e.inc  = 24'(pts[i]);
                    e.idx  = 16'(i);
                    e.done = rp ? (pass > 0 && i == 0 && d == 0)
                                : (i == pts.size() - 1 && d == dw);
                    sb.push_back(e);
                    cnt++;
                end
            end
            if (!rp) begin
                if (cnt < lim) begin
                    push_idle();
                    cnt++;
                end
                break;
            end
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s/sb_empty observed=0 expected=nonzero", phase);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("step_stb", 32'(step_stb), 32'(e.stb));
            chk("done", 32'(done), 32'(e.done));
            chk("cfg_out", cfg_out, e.idle ? cfg_in : {cfg_in[31:24], e.inc});
            if (e.busy) chk("point_idx", 32'(point_idx), 32'(e.idx));
        end
    endtask

    task automatic step_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_cycle();
        end
    endtask

    // Drive a start request, queue the expected trace and check the first cycle.
    task automatic launch(input logic [23:0] s, input logic [23:0] st, input logic [23:0] sp,
                          input bit dn, input int dw, input bit rp, input int lim,
                          input bit hold, output int cnt);
        start_inc = s; step_inc = st; stop_inc = sp; dir_down = dn;
        dwell = 24'(dw); repeat_en = rp; start = 1'b1;
        push_sweep(longint'(s), longint'(st), longint'(sp), dn, dw, rp, lim, cnt);
        step_cycles(1);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int n;
        cfg_in = 32'hDEAD_BEEF;
        #3;
        chk("rst_cfg_out", cfg_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stb", 32'(step_stb), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_idx", 32'(point_idx), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        phase = "idle";
        push_idle(); push_idle();
        step_cycles(2);

        phase = "ascending";
        cfg_in = 32'hA512_3456;
        launch(24'd100, 24'd50, 24'd260, 1'b0, 2, 1'b0, 100, 1'b0, n);
        step_cycles(n - 1);

        phase = "descending";
        launch(24'd10, 24'd4, 24'd0, 1'b1, 0, 1'b0, 100, 1'b0, n);
        step_cycles(n - 1);

        phase = "overflow";
        launch(24'hFFFFF0, 24'h20, 24'hFFFFFF, 1'b0, 3, 1'b0, 100, 1'b0, n);
        step_cycles(n - 1);

        phase = "repeat";
        launch(24'd0, 24'd1, 24'd2, 1'b0, 1, 1'b1, 13, 1'b0, n);
        step_cycles(n - 1);
        phase = "abort";
        abort = 1'b1;
        push_idle();
        step_cycles(1);
        abort = 1'b0;
        push_idle();
        step_cycles(1);

        phase = "zero_step";
        launch(24'd7, 24'd0, 24'd100, 1'b0, 2, 1'b1, 9, 1'b0, n);
        step_cycles(n - 1);
        abort = 1'b1;
        push_idle();
        step_cycles(1);
        abort = 1'b0;

        phase = "start_busy";
        launch(24'd100, 24'd50, 24'd260, 1'b0, 2, 1'b0, 100, 1'b1, n);
        start_inc = 24'd999;
        dwell = 24'd0;
        step_cycles(4);
        cfg_in = 32'h3C12_3456;
        step_cycles(1);
        start = 1'b0;
        step_cycles(n - 6);

        phase = "start_abort";
        start = 1'b1; abort = 1'b1;
        push_idle(); push_idle();
        step_cycles(2);
        start = 1'b0; abort = 1'b0;

        phase = "async_reset";
        launch(24'd1000, 24'd10, 24'd5000, 1'b0, 5, 1'b0, 3, 1'b0, n);
        step_cycles(n - 1);
        rst_n = 1'b0;
        #1;
        chk("ar_cfg_out", cfg_out, 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_stb", 32'(step_stb), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        chk("ar_idx", 32'(point_idx), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        push_idle(); push_idle(); push_idle(); push_idle();
        step_cycles(4);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
